// File: rtl/async_counter_pkg.sv
// Shared constants and types for the synchronous toggle-chain counter.
package async_counter_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 4;

    typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

endpackage

// File: rtl/async_counter_tff_stage.sv
// One counter bit: a toggle flop with synchronous active-high clear.
module tff_stage (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= 1'b0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/async_counter.sv
// Free-running WIDTH-bit up-counter built from toggle stages on one clock;
// the AND-chained enable gives ripple-counter order without derived clocks.
module async_counter
    import async_counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] t_en;
    logic [WIDTH-1:0] cnt;

    // Stage i toggles only when every lower bit is 1.
    assign t_en[0] = 1'b1;

    genvar i;
    generate
        for (i = 1; i < WIDTH; i++) begin : g_en
            assign t_en[i] = t_en[i-1] & cnt[i-1];
        end

        for (i = 0; i < WIDTH; i++) begin : g_stage
            tff_stage u_stage (
                .clk (clk),
                .rst (rst),
                .t   (t_en[i]),
                .q   (cnt[i])
            );
        end
    endgenerate

    assign q = cnt;

endmodule

// File: tb/tb_async_counter.sv
// Directed bench for async_counter at WIDTH 4, 1 and 8 against a modulo model.
module tb_async_counter;

    logic       clk;
    logic       rst;
    logic [3:0] q4;
    logic [0:0] q1;
    logic [7:0] q8;

    int checks   = 0;
    int failures = 0;
    int m4 = 0;
    int m1 = 0;
    int m8 = 0;

    async_counter #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .q(q4));
    async_counter #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .q(q1));
    async_counter #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .q(q8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply rst for one edge, advance the model, then compare all widths.
    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            m4 = 0; m1 = 0; m8 = 0;
        end else begin
            m4 = (m4 + 1) % 16;
            m1 = (m1 + 1) % 2;
            m8 = (m8 + 1) % 256;
        end
        chk("w4", {28'd0, q4}, m4);
        chk("w1", {31'd0, q1}, m1);
        chk("w8", {24'd0, q8}, m8);
    endtask

    initial begin
        rst = 1'b1;
        step(1'b1);
        chk("reset_q0", {28'd0, q4}, 32'd0);
        step(1'b1);

        step(1'b0);
        chk("first_cnt", {28'd0, q4}, 32'd1);
        chk("first_w1", {31'd0, q1}, 32'd1);
        step(1'b0);
        chk("second_cnt", {28'd0, q4}, 32'd2);
        chk("second_w1", {31'd0, q1}, 32'd0);
        for (int k = 3; k <= 15; k++) step(1'b0);
        chk("reach_max", {28'd0, q4}, 32'hf);
        step(1'b0);
        chk("wrap_zero", {28'd0, q4}, 32'd0);
        chk("w8_no_wrap", {24'd0, q8}, 32'd16);
        step(1'b0);
        chk("wrap_resume", {28'd0, q4}, 32'd1);
        for (int k = 0; k < 3; k++) step(1'b0);
        chk("twenty_edges", {28'd0, q4}, 32'h4);

        for (int k = 0; k < 3; k++) step(1'b0);
        chk("at_seven", {28'd0, q4}, 32'h7);
        step(1'b1);
        chk("mid_reset", {28'd0, q4}, 32'd0);
        step(1'b0);
        chk("mid_release", {28'd0, q4}, 32'd1);

        for (int k = 0; k < 5; k++) begin
            step(1'b1);
            chk("held_reset", {28'd0, q4}, 32'd0);
        end

        for (int k = 0; k < 15; k++) step(1'b0);
        chk("pre_wrap", {28'd0, q4}, 32'hf);
        step(1'b1);
        chk("reset_on_wrap", {28'd0, q4}, 32'd0);
        step(1'b0);
        chk("after_wrap_rst", {28'd0, q4}, 32'd1);

        step(1'b1);
        for (int k = 0; k < 255; k++) step(1'b0);
        chk("w8_max", {24'd0, q8}, 32'hff);
        step(1'b0);
        chk("w8_wrap", {24'd0, q8}, 32'd0);
        step(1'b0);
        chk("w8_resume", {24'd0, q8}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
